multi_cntdown_timer: RTL and testbench

MULTI_CNTDOWN_TIMER -- requirements
Module: multi_cntdown_timer

---
 rtl/multi_cntdown_timer.sv | 177 +++++++++++++++++
 tb/tb_multi_cntdown_timer.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_cntdown_timer.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | multi_cntdown_timer: CHANNELS independent countdown timers sharing one key |
// | set. Optional macro CNTDOWN_AUTO_RELOAD_EN adds a per-channel preset.       |
// | Revision: 1.0                                                               |
// +-----------------------------------------------------------------------------+
module multi_cntdown_timer #(
  parameter int CHANNELS   = 4,
  parameter int MAX_SECS   = 59999,
  parameter int ALARM_SECS = 5,
  localparam int BITS      = $clog2(MAX_SECS + 1),
  localparam int SW        = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                CLK,
  input  logic                CLR,
  input  logic                CE,
  input  logic                TICK,
  input  logic                BTN_SEL,
  input  logic                BTN_RUN,
  input  logic                BTN_MIN_INC,
  input  logic                BTN_MIN_DEC,
  input  logic                BTN_SEC_INC,
  input  logic                BTN_SEC_DEC,
  output logic [SW-1:0]       SEL,
  output logic [BITS-1:0]     Q,
  output logic [CHANNELS-1:0] RUNNING,
  output logic [CHANNELS-1:0] ALARM,
  output logic                ANY_ALARM
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_ALARM = 2'd3
  } state_t;

  state_t          state_q [CHANNELS];
  state_t          state_d [CHANNELS];
  logic [BITS-1:0] cnt_q   [CHANNELS];
  logic [BITS-1:0] cnt_d   [CHANNELS];
  logic [BITS-1:0] reload  [CHANNELS];
  logic [7:0]      acnt_q  [CHANNELS];
  logic [7:0]      acnt_d  [CHANNELS];
`ifdef CNTDOWN_AUTO_RELOAD_EN
  logic [BITS-1:0] preset_q [CHANNELS];
  logic [BITS-1:0] preset_d [CHANNELS];
`endif

  logic [SW-1:0]       sel_d;
  logic [CHANNELS-1:0] sel_hit;
  logic                run_evt, min_inc, min_dec, sec_inc, sec_dec;

  function automatic logic [BITS-1:0] sat_add(input logic [BITS-1:0] v, input logic [31:0] d);
    logic [31:0] s;
    s = 32'(v) + d;
    return (s > 32'(MAX_SECS)) ? BITS'(MAX_SECS) : BITS'(s);
  endfunction

  function automatic logic [BITS-1:0] sat_sub(input logic [BITS-1:0] v, input logic [31:0] d);
    return (32'(v) > d) ? BITS'(32'(v) - d) : '0;
  endfunction

  // Only the highest-priority key of a cycle is allowed through.
  assign run_evt = BTN_RUN & ~BTN_SEL;
  assign min_inc = BTN_MIN_INC & ~BTN_SEL & ~BTN_RUN;
  assign min_dec = BTN_MIN_DEC & ~BTN_SEL & ~BTN_RUN & ~BTN_MIN_INC;
  assign sec_inc = BTN_SEC_INC & ~BTN_SEL & ~BTN_RUN & ~BTN_MIN_INC & ~BTN_MIN_DEC;
  assign sec_dec = BTN_SEC_DEC & ~BTN_SEL & ~BTN_RUN & ~BTN_MIN_INC & ~BTN_MIN_DEC
                   & ~BTN_SEC_INC;
  assign sel_hit = CHANNELS'(1) << SEL;

  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
`ifdef CNTDOWN_AUTO_RELOAD_EN
      reload[i] = preset_q[i];
`else
      reload[i] = '0;
`endif
    end
  end

  always_comb begin
    sel_d = SEL;
    if (CE && BTN_SEL) sel_d = (SEL == SW'(CHANNELS - 1)) ? '0 : SEL + 1'b1;
    for (int i = 0; i < CHANNELS; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      acnt_d[i]  = acnt_q[i];
`ifdef CNTDOWN_AUTO_RELOAD_EN
      preset_d[i] = preset_q[i];
`endif
      if (CE) begin
        if (sel_hit[i] && run_evt) begin
          // A key press on this channel swallows a coincident TICK.
          unique case (state_q[i])
            ST_IDLE: begin
              if (cnt_q[i] != '0) begin
                state_d[i] = ST_RUN;
`ifdef CNTDOWN_AUTO_RELOAD_EN
                preset_d[i] = cnt_q[i];
`endif
              end
            end
            ST_RUN:   state_d[i] = ST_PAUSE;
            ST_PAUSE: state_d[i] = ST_RUN;
            default: begin
              state_d[i] = ST_IDLE;
              acnt_d[i]  = '0;
              cnt_d[i]   = reload[i];
            end
          endcase
        end else begin
          if (sel_hit[i] && (state_q[i] == ST_IDLE || state_q[i] == ST_PAUSE)) begin
            if (min_inc)      cnt_d[i] = sat_add(cnt_q[i], 32'd60);
            else if (min_dec) cnt_d[i] = sat_sub(cnt_q[i], 32'd60);
            else if (sec_inc) cnt_d[i] = sat_add(cnt_q[i], 32'd1);
            else if (sec_dec) cnt_d[i] = sat_sub(cnt_q[i], 32'd1);
          end
          if (TICK) begin
            if (state_q[i] == ST_RUN) begin
              // A run resumed at zero after editing also expires on the next TICK.
              if (cnt_q[i] <= BITS'(1)) begin
                state_d[i] = ST_ALARM;
                cnt_d[i]   = '0;
                acnt_d[i]  = 8'(ALARM_SECS);
              end else begin
                cnt_d[i] = cnt_q[i] - 1'b1;
              end
            end else if (state_q[i] == ST_ALARM) begin
              if (acnt_q[i] <= 8'd1) begin
                state_d[i] = ST_IDLE;
                acnt_d[i]  = '0;
                cnt_d[i]   = reload[i];
              end else begin
                acnt_d[i] = acnt_q[i] - 1'b1;
              end
            end
          end
        end
      end
    end
  end

  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      SEL     <= '0;
      RUNNING <= '0;
      ALARM   <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        state_q[i] <= ST_IDLE;
        cnt_q[i]   <= '0;
        acnt_q[i]  <= '0;
`ifdef CNTDOWN_AUTO_RELOAD_EN
        preset_q[i] <= '0;
`endif
      end
    end else begin
      SEL <= sel_d;
      for (int i = 0; i < CHANNELS; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
        acnt_q[i]  <= acnt_d[i];
        RUNNING[i] <= (state_d[i] == ST_RUN);
        ALARM[i]   <= (state_d[i] == ST_ALARM);
`ifdef CNTDOWN_AUTO_RELOAD_EN
        preset_q[i] <= preset_d[i];
`endif
      end
    end
  end

  assign Q         = cnt_q[SEL];
  assign ANY_ALARM = |ALARM;

endmodule
`default_nettype wire

// File: tb/tb_multi_cntdown_timer.sv
`default_nettype none
// Scoreboard bench for multi_cntdown_timer: directed scenarios plus random key/TICK traffic
// checked against an arithmetic reference model.
module tb_multi_cntdown_timer;
  localparam int CH   = 4;
  localparam int MAXS = 59999;
  localparam int ALS  = 5;
  localparam int BITS = $clog2(MAXS + 1);
  localparam int SW   = 2;
`ifdef CNTDOWN_AUTO_RELOAD_EN
  localparam bit RELOAD = 1'b1;
`else
  localparam bit RELOAD = 1'b0;
`endif
  localparam int S_IDLE = 0, S_RUN = 1, S_PAUSE = 2, S_ALARM = 3;
  localparam int K_NONE = 0, K_SEL = 1, K_RUN = 2, K_MI = 3, K_MD = 4, K_SI = 5, K_SD = 6;

  logic CLK = 1'b0;
  logic CLR, CE, TICK, BTN_SEL, BTN_RUN, BTN_MIN_INC, BTN_MIN_DEC, BTN_SEC_INC, BTN_SEC_DEC;
  logic [SW-1:0]   SEL;
  logic [BITS-1:0] Q;
  logic [CH-1:0]   RUNNING, ALARM;
  logic            ANY_ALARM;

  always #5 CLK = ~CLK;

  multi_cntdown_timer #(.CHANNELS(CH), .MAX_SECS(MAXS), .ALARM_SECS(ALS)) dut (
    .CLK(CLK), .CLR(CLR), .CE(CE), .TICK(TICK),
    .BTN_SEL(BTN_SEL), .BTN_RUN(BTN_RUN),
    .BTN_MIN_INC(BTN_MIN_INC), .BTN_MIN_DEC(BTN_MIN_DEC),
    .BTN_SEC_INC(BTN_SEC_INC), .BTN_SEC_DEC(BTN_SEC_DEC),
    .SEL(SEL), .Q(Q), .RUNNING(RUNNING), .ALARM(ALARM), .ANY_ALARM(ANY_ALARM)
  );

  typedef struct packed {
    logic [SW-1:0]   sel;
    logic [BITS-1:0] q;
    logic [CH-1:0]   running;
    logic [CH-1:0]   alarm;
    logic            any;
  } obs_t;

  obs_t expq[$];
  obs_t mon_exp, mon_got;
  int checks = 0, failures = 0;

  int m_cnt[CH], m_acnt[CH], m_st[CH], m_pre[CH];
  int m_sel;

  task automatic model_reset();
    m_sel = 0;
    for (int c = 0; c < CH; c++) begin
      m_cnt[c] = 0; m_acnt[c] = 0; m_st[c] = S_IDLE; m_pre[c] = 0;
    end
  endtask

  function automatic obs_t model_obs();
    obs_t o;
    o.sel = SW'(m_sel);
    o.q   = BITS'(m_cnt[m_sel]);
    for (int c = 0; c < CH; c++) begin
      o.running[c] = (m_st[c] == S_RUN);
      o.alarm[c]   = (m_st[c] == S_ALARM);
    end
    o.any = |o.alarm;
    return o;
  endfunction

  task automatic model_step(input bit ce, tick, bs, br, mi, md, si, sd);
    int skip = -1;
    int s;
    if (!ce) return;
    s = m_sel;
    if (bs) begin
      m_sel = (m_sel + 1) % CH;
    end else if (br) begin
      skip = s;
      case (m_st[s])
        S_IDLE:  if (m_cnt[s] > 0) begin m_st[s] = S_RUN; m_pre[s] = m_cnt[s]; end
        S_RUN:   m_st[s] = S_PAUSE;
        S_PAUSE: m_st[s] = S_RUN;
        default: begin m_st[s] = S_IDLE; m_acnt[s] = 0; m_cnt[s] = RELOAD ? m_pre[s] : 0; end
      endcase
    end else if (m_st[s] == S_IDLE || m_st[s] == S_PAUSE) begin
      if (mi)      m_cnt[s] = (m_cnt[s] + 60 > MAXS) ? MAXS : m_cnt[s] + 60;
      else if (md) m_cnt[s] = (m_cnt[s] < 60) ? 0 : m_cnt[s] - 60;
      else if (si) m_cnt[s] = (m_cnt[s] + 1 > MAXS) ? MAXS : m_cnt[s] + 1;
      else if (sd) m_cnt[s] = (m_cnt[s] < 1) ? 0 : m_cnt[s] - 1;
    end
    if (tick) begin
      for (int c = 0; c < CH; c++) begin
        if (c == skip) continue;
        if (m_st[c] == S_RUN) begin
          if (m_cnt[c] <= 1) begin m_cnt[c] = 0; m_st[c] = S_ALARM; m_acnt[c] = ALS; end
          else m_cnt[c] = m_cnt[c] - 1;
        end else if (m_st[c] == S_ALARM) begin
          m_acnt[c] = m_acnt[c] - 1;
          if (m_acnt[c] == 0) begin m_st[c] = S_IDLE; m_cnt[c] = RELOAD ? m_pre[c] : 0; end
        end
      end
    end
  endtask

  task automatic step(input bit ce, tick, bs, br, mi, md, si, sd);
    @(negedge CLK);
    CE = ce; TICK = tick; BTN_SEL = bs; BTN_RUN = br;
    BTN_MIN_INC = mi; BTN_MIN_DEC = md; BTN_SEC_INC = si; BTN_SEC_DEC = sd;
    @(posedge CLK);
    model_step(ce, tick, bs, br, mi, md, si, sd);
    expq.push_back(model_obs());
    #2;
  endtask

  task automatic cyc(input int k, input bit tick = 1'b0, input bit ce = 1'b1);
    step(ce, tick, k == K_SEL, k == K_RUN, k == K_MI, k == K_MD, k == K_SI, k == K_SD);
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  always @(posedge CLK) begin
    #1;
    if (expq.size() > 0) begin
      mon_exp = expq.pop_front();
      mon_got = {SEL, Q, RUNNING, ALARM, ANY_ALARM};
      checks++;
      if (mon_got !== mon_exp) begin
        failures++;
        $display("FAIL scoreboard t=%0t: got sel=%0d q=%0d run=%b alm=%b any=%b expected sel=%0d q=%0d run=%b alm=%b any=%b",
                 $time, mon_got.sel, mon_got.q, mon_got.running, mon_got.alarm, mon_got.any,
                 mon_exp.sel, mon_exp.q, mon_exp.running, mon_exp.alarm, mon_exp.any);
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    CLR = 1'b0; CE = 1'b1; TICK = 1'b0; BTN_SEL = 1'b0; BTN_RUN = 1'b0;
    BTN_MIN_INC = 1'b0; BTN_MIN_DEC = 1'b0; BTN_SEC_INC = 1'b0; BTN_SEC_DEC = 1'b0;
    model_reset();
    #22;
    chk("reset_sel", 32'(SEL), 0);
    chk("reset_q", 32'(Q), 0);
    chk("reset_running", 32'(RUNNING), 0);
    chk("reset_alarm", 32'(ALARM), 0);
    chk("reset_any", 32'(ANY_ALARM), 0);
    @(negedge CLK); CLR = 1'b1;

    // Basic countdown into alarm and timeout back to IDLE.
    repeat (3) cyc(K_SI);
    cyc(K_RUN);
    chk("cd_start", 32'(Q), 3);
    cyc(K_NONE, 1); chk("cd_tick1", 32'(Q), 2);
    cyc(K_NONE, 1); chk("cd_tick2", 32'(Q), 1);
    cyc(K_NONE, 1); chk("cd_tick3", 32'(Q), 0);
    chk("cd_alarm0", 32'(ALARM[0]), 1);
    chk("cd_any", 32'(ANY_ALARM), 1);
    repeat (5) cyc(K_NONE, 1);
    chk("cd_alarm_end", 32'(ALARM[0]), 0);
    chk("cd_idle", 32'(RUNNING[0]), 0);

    // Saturation at both ends.
    cyc(K_MD);
    repeat (999) cyc(K_MI);
    repeat (50) cyc(K_SI);
    chk("sat_pre", 32'(Q), 59990);
    cyc(K_MI); chk("sat_max", 32'(Q), 59999);
    repeat (999) cyc(K_MD);
    repeat (29) cyc(K_SD);
    chk("sat_30", 32'(Q), 30);
    cyc(K_MD); chk("sat_min", 32'(Q), 0);
    cyc(K_SD); chk("sat_sec_min", 32'(Q), 0);

    // Channel select wrap and channel independence.
    cyc(K_SEL); chk("sel1", 32'(SEL), 1);
    cyc(K_SEL); chk("sel2", 32'(SEL), 2);
    cyc(K_SEL); chk("sel3", 32'(SEL), 3);
    cyc(K_SEL); chk("sel_wrap", 32'(SEL), 0);
    cyc(K_SEL);
    repeat (10) cyc(K_SI);
    cyc(K_RUN);
    cyc(K_SEL);
    repeat (4) cyc(K_NONE, 1);
    chk("ch2_unchanged", 32'(Q), 0);
    repeat (3) cyc(K_SEL);
    chk("ch1_after_4", 32'(Q), 6);
    cyc(K_RUN);
    repeat (3) cyc(K_SEL);

    // BTN_RUN wins over a coincident TICK.
    repeat (10) cyc(K_SI);
    cyc(K_RUN);
    cyc(K_RUN, 1);
    chk("pause_q", 32'(Q), 10);
    chk("pause_state", 32'(RUNNING[0]), 0);
    repeat (2) cyc(K_NONE, 1);
    chk("pause_hold", 32'(Q), 10);
    cyc(K_SI); chk("pause_edit", 32'(Q), 11);

    // Acknowledge with optional reload.
    repeat (9) cyc(K_SD);
    cyc(K_RUN);
    repeat (7) cyc(K_NONE, 1);
    cyc(K_MD);
    repeat (2) cyc(K_SI);
    cyc(K_RUN);
    repeat (2) cyc(K_NONE, 1);
    chk("ack_alarm", 32'(ALARM[0]), 1);
    cyc(K_RUN);
    chk("ack_q", 32'(Q), RELOAD ? 2 : 0);
    chk("ack_alarm_off", 32'(ALARM[0]), 0);

    // Asynchronous reset mid-run.
    repeat (5) cyc(K_SI);
    cyc(K_RUN);
    cyc(K_NONE, 1);
    @(negedge CLK); #2;
    CLR = 1'b0;
    #1;
    chk("areset_q", 32'(Q), 0);
    chk("areset_sel", 32'(SEL), 0);
    chk("areset_running", 32'(RUNNING), 0);
    chk("areset_alarm", 32'(ALARM), 0);
    @(negedge CLK); CLR = 1'b1;
    model_reset();
    cyc(K_NONE, 1);
    chk("areset_no_pending", 32'(RUNNING), 0);

    // Clock enable freeze.
    repeat (4) cyc(K_SI);
    cyc(K_RUN);
    repeat (3) cyc(K_NONE, 1, 0);
    chk("ce_freeze_q", 32'(Q), 4);
    cyc(K_SEL, 1, 0);
    chk("ce_freeze_sel", 32'(SEL), 0);
    cyc(K_NONE, 1);
    chk("ce_resume", 32'(Q), 3);

    // Random traffic, including coincident keys.
    for (int n = 0; n < 3000; n++) begin
      step(($urandom % 8) != 0, ($urandom % 4) == 0,
           ($urandom % 10) == 0, ($urandom % 8) == 0,
           ($urandom % 12) == 0, ($urandom % 12) == 0,
           ($urandom % 6) == 0, ($urandom % 10) == 0);
    end

    @(negedge CLK);
    CE = 1'b1; TICK = 1'b0; BTN_SEL = 1'b0; BTN_RUN = 1'b0;
    BTN_MIN_INC = 1'b0; BTN_MIN_DEC = 1'b0; BTN_SEC_INC = 1'b0; BTN_SEC_DEC = 1'b0;
    repeat (3) @(posedge CLK);
    #2;
    chk("queue_drained", 32'(expq.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire
